// File: rtl/digital_tube_ctrl.sv
// rtl/digital_tube_ctrl.sv - memory-mapped three-group seven-segment tube driver
// DATA/AUX/CTRL registers; tube0/tube1 scan DATA nibbles, tube2 shows AUX statically.
module digital_tube_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  digital_tube0,
  output logic [3:0]  digital_tube_sel0,
  output logic [7:0]  digital_tube1,
  output logic [3:0]  digital_tube_sel1,
  output logic [7:0]  digital_tube2,
  output logic        digital_tube_sel2
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  localparam logic [7:0] SEG_ZERO  = 8'hC0;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  logic [31:0]   r_data;
  logic [3:0]    r_aux;
  logic          r_en;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;

  logic          w_wr_data;
  logic          w_wr_aux;
  logic          w_wr_ctrl;
  logic          w_wrap;
  logic [3:0]    w_nib0;
  logic [3:0]    w_nib1;
  logic [3:0]    w_sel;
  logic          w_unused_addr;

  function automatic logic [7:0] enc(input logic [3:0] h);
    logic [7:0] s;
    case (h)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign w_unused_addr = ^addr[1:0];

  assign w_wr_data = we && (addr[3:2] == 2'd0);
  assign w_wr_aux  = we && (addr[3:2] == 2'd1);
  assign w_wr_ctrl = we && (addr[3:2] == 2'd2);
  assign w_wrap    = (r_cnt == CNT_LAST);

  always_comb begin
    w_nib0 = r_data[3:0];
    w_nib1 = r_data[19:16];
    w_sel  = 4'b0001;
    case (r_idx)
      2'd0: begin
        w_nib0 = r_data[3:0];
        w_nib1 = r_data[19:16];
        w_sel  = 4'b0001;
      end
      2'd1: begin
        w_nib0 = r_data[7:4];
        w_nib1 = r_data[23:20];
        w_sel  = 4'b0010;
      end
      2'd2: begin
        w_nib0 = r_data[11:8];
        w_nib1 = r_data[27:24];
        w_sel  = 4'b0100;
      end
      default: begin
        w_nib0 = r_data[15:12];
        w_nib1 = r_data[31:28];
        w_sel  = 4'b1000;
      end
    endcase
  end

  always_comb begin
    rdata = 32'd0;
    case (addr[3:2])
      2'd0:    rdata = r_data;
      2'd1:    rdata = {28'd0, r_aux};
      2'd2:    rdata = {31'd0, r_en};
      default: rdata = 32'd0;
    endcase
  end

  // Scan counter free-runs independent of EN so re-enabling resumes at the live digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= 32'd0;
      r_aux  <= 4'd0;
      r_en   <= 1'b1;
    end else begin
      if (w_wr_data) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) r_data[8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      if (w_wr_aux)  r_aux <= wdata[3:0];
      if (w_wr_ctrl) r_en  <= wdata[0];
    end
  end

  // Outputs sample pre-edge register state, giving one edge of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      digital_tube0     <= SEG_ZERO;
      digital_tube1     <= SEG_ZERO;
      digital_tube2     <= SEG_ZERO;
      digital_tube_sel0 <= 4'b0001;
      digital_tube_sel1 <= 4'b0001;
      digital_tube_sel2 <= 1'b1;
    end else if (r_en) begin
      digital_tube0     <= enc(w_nib0);
      digital_tube1     <= enc(w_nib1);
      digital_tube2     <= enc(r_aux);
      digital_tube_sel0 <= w_sel;
      digital_tube_sel1 <= w_sel;
      digital_tube_sel2 <= 1'b1;
    end else begin
      digital_tube0     <= SEG_BLANK;
      digital_tube1     <= SEG_BLANK;
      digital_tube2     <= SEG_BLANK;
      digital_tube_sel0 <= 4'b0000;
      digital_tube_sel1 <= 4'b0000;
      digital_tube_sel2 <= 1'b0;
    end
  end

endmodule
